mul_div_iter: RTL and testbench
===============================

Name: mul_div_iter

Overview:
- Parametrised iterative multiply/divide/accumulate unit. It is the multi-cycle successor to the single-cycle combinational multiply path in the execute stage.
- Computes signed/unsigned multiply, multiply-accumulate/subtract and divide over W-bit operands, producing a 2W-bit {hi,lo} result.
- Sits beside the execute stage. The pipeline stalls on busy_o and writes hi_o/lo_o to the HI/LO file when done_o pulses.

Parameters:
W, 32, operand width in bits; hi_o/lo_o are each W bits; iteration count = W.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start_i  in  1  request; accepted only when ready_o=1.
op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
opdata1_i  in  W  multiplicand / dividend.
opdata2_i  in  W  multiplier / divisor.
hi_i  in  W  accumulator high half (MADD/MSUB only), forwarded HI value.
lo_i  in  W  accumulator low half (MADD/MSUB only), forwarded LO value.
annul_i  in  1  synchronous cancel of the operation in flight.
ready_o  out  1  high in IDLE.
busy_o  out  1  high in CALC and FIX.
done_o  out  1  one-cycle result-valid pulse.
dz_o  out  1  divide-by-zero flag; valid with done_o.
hi_o  out  W  result high half: product[2W-1:W] or remainder.
lo_o  out  W  result low half: product[W-1:0] or quotient.

Behaviour:
- **Reset** (rst=0, asynchronous): state=IDLE. ready_o=1. busy_o=0, done_o=0, dz_o=0, hi_o=0, lo_o=0. Counter and operand registers are cleared. This holds even mid-operation.
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - start_i=1 at edge N latches op_i, both operands and {hi_i,lo_i}.
  - For signed ops (MULT, DIV, MADD, MSUB) the operands are latched as magnitudes, and the result sign is recorded as sign1^sign2. For DIV the remainder sign is also recorded as sign1.
  - DIV/DIVU with opdata2_i=0: go directly to DONE at edge N with dz_o=1, hi_o=opdata1_i, lo_o={W{1}}. done_o is therefore high in the cycle after edge N.
  - All other requests: go to CALC with counter=0.
- **CALC:** one iteration per cycle, W iterations at edges N+1..N+W.
  - Multiply: shift-add, 2W-bit partial product.
  - Divide: restoring, one quotient bit per cycle.
  - At the W-th iteration, go to FIX.
- **FIX:** one cycle, edge N+W+1.
  - Negate the product or quotient if the result sign is 1. Negate the remainder if the dividend was negative.
  - MADD/MADDU: {hi,lo} = acc + product. MSUB/MSUBU: {hi,lo} = acc − product. Both wrap modulo 2^(2W).
  - Register hi_o/lo_o, then go to DONE.
- **DONE:** done_o=1 for exactly one cycle, then IDLE. Normal latency: done_o is high in the cycle after edge N+W+1 (W+2 edges from start).
- **Divide rules:**
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives quotient = 2^(W−1) (pattern 100…0) and remainder = 0, with no flag.
- **Output hold:** hi_o/lo_o hold their last value until the next FIX or dz completion. dz_o is cleared at every non-dz acceptance.
- **Ignored inputs:** start_i while not IDLE is ignored, with no queuing. start_i in DONE is also ignored; ready_o=0 in DONE.
- **annul_i:**
  - In CALC or FIX: return to IDLE at the next edge. No done_o, and hi_o/lo_o are unchanged.
  - In IDLE: ignored. annul_i together with start_i in IDLE: annul wins and the request is not accepted.
  - In DONE: ignored; the pulse completes.
- **Control outputs:** ready_o=(state==IDLE) and busy_o=(state==CALC||state==FIX), both decoded from registered state.

Test Plan:
- MULT 0xFFFFFFFE × 3, started at edge N -> done_o only in the cycle after edge N+33; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA; busy_o=1 for 33 cycles. MULTU of the same operands -> hi_o=0x00000002, lo_o=0xFFFFFFFA.
- DIVU 100/7 -> lo_o=14, hi_o=2. DIV −7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0, dz_o=0.
- DIV 5/0 -> done_o one cycle after the start edge, dz_o=1, hi_o=5, lo_o=0xFFFFFFFF. A following MULT 2×2 -> dz_o=0, lo_o=4.
- MADDU hi_i=0, lo_i=0xFFFFFFFF, 1×1 -> hi_o=1, lo_o=0. MSUB hi_i=lo_i=0, 2×3 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
- Start MULT, assert start_i with new operands at iteration 5, then annul_i at iteration 10 -> no done_o, ready_o=1 next cycle, hi_o/lo_o keep the previous results, second start not executed.
- Drop rst to 0 mid-CALC, asynchronously between edges -> all outputs 0 and ready_o=1 immediately. After release, DIVU 9/3 -> lo_o=3, hi_o=0.

Source files
------------

// File: rtl/mul_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_iter
//  Description : Iterative W-cycle multiply / multiply-accumulate / divide unit
//                producing a 2W-bit {hi,lo} result for the HI/LO file.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_iter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [2:0]   op_i,
   input  logic [W-1:0] opdata1_i,
   input  logic [W-1:0] opdata2_i,
   input  logic [W-1:0] hi_i,
   input  logic [W-1:0] lo_i,
   input  logic         annul_i,
   output logic         ready_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         dz_o,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o
);

   localparam int              c_CW   = (W > 1) ? $clog2(W) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(W - 1);
   localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [c_CW-1:0] r_cnt;
   logic [1:0]      r_op_cls;
   logic            r_neg_res;
   logic            r_neg_rem;
   logic [2*W-1:0]  r_mcand;
   logic [W-1:0]    r_mplier;
   logic [W-1:0]    r_rem;
   logic [2*W-1:0]  r_prod;
   logic [2*W-1:0]  r_acc;
   logic            r_dz;
   logic [W-1:0]    r_hi;
   logic [W-1:0]    r_lo;

   // Request decode and operand magnitudes
   logic            w_in_signed;
   logic            w_in_div;
   logic            w_s1;
   logic            w_s2;
   logic [W-1:0]    w_mag1;
   logic [W-1:0]    w_mag2;
   logic            w_accept;
   logic            w_dz_req;

   assign w_in_signed = ~op_i[0];
   assign w_in_div    = (op_i[2:1] == 2'b01);
   assign w_s1        = w_in_signed & opdata1_i[W-1];
   assign w_s2        = w_in_signed & opdata2_i[W-1];
   assign w_mag1      = w_s1 ? (-opdata1_i) : opdata1_i;
   assign w_mag2      = w_s2 ? (-opdata2_i) : opdata2_i;
   assign w_accept    = (r_state == S_IDLE) & start_i & ~annul_i;
   assign w_dz_req    = w_in_div & (opdata2_i == '0);

   // Restoring-divide step: r_mplier shifts the dividend out and the quotient in
   logic            w_is_div;
   logic [W:0]      w_shift;
   logic [W:0]      w_trial;
   logic            w_fits;

   assign w_is_div = (r_op_cls == 2'b01);
   assign w_shift  = {r_rem, r_mplier[W-1]};
   assign w_trial  = w_shift - {1'b0, r_mcand[W-1:0]};
   assign w_fits   = ~w_trial[W];

   // Sign fix-up and accumulation
   logic [2*W-1:0]  w_prod_s;
   logic [W-1:0]    w_quot;
   logic [W-1:0]    w_remf;
   logic [2*W-1:0]  w_mres;
   logic [2*W-1:0]  w_result;

   assign w_prod_s = r_neg_res ? (-r_prod) : r_prod;
   assign w_quot   = r_neg_res ? (-r_mplier) : r_mplier;
   assign w_remf   = r_neg_rem ? (-r_rem) : r_rem;

   always_comb begin
      w_mres = w_prod_s;
      case (r_op_cls)
         2'b10:   w_mres = r_acc + w_prod_s;
         2'b11:   w_mres = r_acc - w_prod_s;
         default: w_mres = w_prod_s;
      endcase
   end

   assign w_result = w_is_div ? {w_remf, w_quot} : w_mres;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      ready_o     = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready_o = 1'b1;
            if (w_accept) begin
               w_state_nxt = w_dz_req ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            busy_o = 1'b1;
            if (annul_i) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == c_LAST) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            busy_o      = 1'b1;
            w_state_nxt = annul_i ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_op_cls  <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_rem     <= '0;
         r_prod    <= '0;
         r_acc     <= '0;
         r_dz      <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt     <= '0;
                  r_op_cls  <= op_i[2:1];
                  r_neg_res <= w_s1 ^ w_s2;
                  r_neg_rem <= w_s1;
                  // Divide keeps the divisor in the low half of r_mcand
                  r_mcand   <= {{W{1'b0}}, (w_in_div ? w_mag2 : w_mag1)};
                  r_mplier  <= w_in_div ? w_mag1 : w_mag2;
                  r_rem     <= '0;
                  r_prod    <= '0;
                  r_acc     <= {hi_i, lo_i};
                  if (w_dz_req) begin
                     r_dz <= 1'b1;
                     r_hi <= opdata1_i;
                     r_lo <= '1;
                  end else begin
                     r_dz <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + c_ONE;
               if (w_is_div) begin
                  r_rem    <= w_fits ? w_trial[W-1:0] : w_shift[W-1:0];
                  r_mplier <= {r_mplier[W-2:0], w_fits};
               end else begin
                  r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
               end
            end
            S_FIX: begin
               if (!annul_i) begin
                  r_hi <= w_result[2*W-1:W];
                  r_lo <= w_result[W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign dz_o = r_dz;
   assign hi_o = r_hi;
   assign lo_o = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_iter
//  Description : Self-checking bench for mul_div_iter against a timeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_iter;

   localparam int W = 32;

   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         start_i   = 1'b0;
   logic [2:0]   op_i      = '0;
   logic [W-1:0] opdata1_i = '0;
   logic [W-1:0] opdata2_i = '0;
   logic [W-1:0] hi_i      = '0;
   logic [W-1:0] lo_i      = '0;
   logic         annul_i   = 1'b0;
   logic         ready_o;
   logic         busy_o;
   logic         done_o;
   logic         dz_o;
   logic [W-1:0] hi_o;
   logic [W-1:0] lo_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_div_iter #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .op_i      (op_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .hi_i      (hi_i),
      .lo_i      (lo_i),
      .annul_i   (annul_i),
      .ready_o   (ready_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .dz_o      (dz_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference: result {hi,lo} of one operation
   function automatic logic [63:0] model_res(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] h,
                                             input logic [W-1:0] l);
      logic signed [63:0] sa, sb, sq, sr;
      logic [63:0]        ua, ub, p, acc;
      sa  = {{W{a[W-1]}}, a};
      sb  = {{W{b[W-1]}}, b};
      ua  = {{W{1'b0}}, a};
      ub  = {{W{1'b0}}, b};
      acc = {h, l};
      if ((op == 3'd2 || op == 3'd3) && b == '0) return {a, {W{1'b1}}};
      if (op[0]) p = ua * ub;
      else       p = sa * sb;
      case (op)
         3'd2: begin
            sq = sa / sb;
            sr = sa % sb;
            return {sr[W-1:0], sq[W-1:0]};
         end
         3'd3:       return {a % b, a / b};
         3'd4, 3'd5: return acc + p;
         3'd6, 3'd7: return acc - p;
         default:    return p;
      endcase
   endfunction

   // Timeline model: accepted at edge N, done in the cycle after edge N+len
   logic         m_act = 1'b0;
   int           m_n   = 0;
   int           m_len = 0;
   int           m_e   = 0;
   logic [63:0]  m_res = '0;
   logic [W-1:0] m_hi  = '0;
   logic [W-1:0] m_lo  = '0;
   logic         m_dz  = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_act <= 1'b0;
         m_hi  <= '0;
         m_lo  <= '0;
         m_dz  <= 1'b0;
      end else begin
         m_e <= m_e + 1;
         if (m_act) begin
            if (annul_i && (m_e + 1 <= m_n + m_len)) begin
               m_act <= 1'b0;
            end else if (m_e + 1 == m_n + m_len) begin
               m_hi <= m_res[63:32];
               m_lo <= m_res[31:0];
            end else if (m_e + 1 == m_n + m_len + 1) begin
               m_act <= 1'b0;
            end
         end else if (start_i && !annul_i) begin
            m_act <= 1'b1;
            m_n   <= m_e + 1;
            if ((op_i == 3'd2 || op_i == 3'd3) && opdata2_i == '0) begin
               m_len <= 0;
               m_dz  <= 1'b1;
               m_hi  <= opdata1_i;
               m_lo  <= '1;
            end else begin
               m_len <= W + 1;
               m_dz  <= 1'b0;
               m_res <= model_res(op_i, opdata1_i, opdata2_i, hi_i, lo_i);
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("ready_o", 64'(ready_o), 64'(!m_act));
      chk("busy_o",  64'(busy_o),  64'(m_act && m_len != 0 && m_e <= m_n + W));
      chk("done_o",  64'(done_o),  64'(m_act && m_e == m_n + m_len));
      chk("dz_o",    64'(dz_o),    64'(m_dz));
      chk("hi_lo",   {hi_o, lo_o}, {m_hi, m_lo});
   end

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] h, input logic [W-1:0] l,
                         output int lat, output int nbusy);
      @(negedge clk);
      start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hi_i = h; lo_i = l;
      @(negedge clk);
      start_i = 1'b0;
      lat = -1;
      nbusy = 0;
      for (int i = 0; i < W + 8; i++) begin
         if (done_o) begin
            lat = i;
            break;
         end
         if (busy_o) nbusy++;
         @(negedge clk);
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return W'(1);
         2:       return '1;
         3:       return {1'b1, {(W-1){1'b0}}};
         4:       return {1'b0, {(W-1){1'b1}}};
         5:       return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nb, ndone;

      chk("model_mult",   model_res(3'd0, 32'hFFFFFFFE, 32'd3, '0, '0), 64'hFFFFFFFF_FFFFFFFA);
      chk("model_multu",  model_res(3'd1, 32'hFFFFFFFE, 32'd3, '0, '0), 64'h00000002_FFFFFFFA);
      chk("model_div",    model_res(3'd2, 32'hFFFFFFF9, 32'd2, '0, '0), 64'hFFFFFFFF_FFFFFFFD);
      chk("model_divovf", model_res(3'd2, 32'h80000000, 32'hFFFFFFFF, '0, '0), 64'h00000000_80000000);
      chk("model_msub",   model_res(3'd6, 32'd2, 32'd3, '0, '0), 64'hFFFFFFFF_FFFFFFFA);

      #1 rst = 1'b0;
      #1;
      chk("reset_ready", 64'(ready_o), 64'd1);
      chk("reset_out",   {hi_o, lo_o}, 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      run_op(3'd0, 32'hFFFFFFFE, 32'd3, '0, '0, lat, nb);
      chk("mult_latency", 64'(lat), 64'(W + 1));
      chk("mult_busy",    64'(nb),  64'(W + 1));
      chk("mult_res",     {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);
      run_op(3'd1, 32'hFFFFFFFE, 32'd3, '0, '0, lat, nb);
      chk("multu_res",    {hi_o, lo_o}, 64'h00000002_FFFFFFFA);
      run_op(3'd3, 32'd100, 32'd7, '0, '0, lat, nb);
      chk("divu_res",     {hi_o, lo_o}, {32'd2, 32'd14});
      run_op(3'd2, 32'hFFFFFFF9, 32'd2, '0, '0, lat, nb);
      chk("div_res",      {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, '0, '0, lat, nb);
      chk("div_ovf_res",  {hi_o, lo_o}, 64'h00000000_80000000);
      chk("div_ovf_dz",   64'(dz_o), 64'd0);
      run_op(3'd2, 32'd5, 32'd0, '0, '0, lat, nb);
      chk("dz_latency",   64'(lat), 64'd0);
      chk("dz_flag",      64'(dz_o), 64'd1);
      chk("dz_res",       {hi_o, lo_o}, 64'h00000005_FFFFFFFF);
      run_op(3'd0, 32'd2, 32'd2, '0, '0, lat, nb);
      chk("after_dz_flag", 64'(dz_o), 64'd0);
      chk("after_dz_res",  {hi_o, lo_o}, 64'd4);
      run_op(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, lat, nb);
      chk("maddu_res",    {hi_o, lo_o}, 64'h00000001_00000000);
      run_op(3'd6, 32'd2, 32'd3, '0, '0, lat, nb);
      chk("msub_res",     {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);

      // Annul mid-calculation with an ignored second request
      @(negedge clk);
      start_i = 1'b1; op_i = 3'd0; opdata1_i = 32'd7; opdata2_i = 32'd9;
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      start_i = 1'b1; op_i = 3'd1; opdata1_i = 32'd3; opdata2_i = 32'd3;
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      chk("annul_ready", 64'(ready_o), 64'd1);
      ndone = 0;
      for (int i = 0; i < W + 8; i++) begin
         if (done_o) ndone++;
         @(negedge clk);
      end
      chk("annul_no_done", 64'(ndone), 64'd0);
      chk("annul_hold",    {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);

      // Annul together with start in IDLE
      start_i = 1'b1; annul_i = 1'b1; op_i = 3'd0; opdata1_i = 32'd1; opdata2_i = 32'd1;
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;
      chk("idle_annul_ready", 64'(ready_o), 64'd1);

      // Asynchronous reset mid-CALC
      start_i = 1'b1; op_i = 3'd0; opdata1_i = 32'd5; opdata2_i = 32'd5;
      @(negedge clk);
      start_i = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_ready", 64'(ready_o), 64'd1);
      chk("async_ctrl",  64'({busy_o, done_o, dz_o}), 64'd0);
      chk("async_out",   {hi_o, lo_o}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_op(3'd3, 32'd9, 32'd3, '0, '0, lat, nb);
      chk("post_reset_divu", {hi_o, lo_o}, 64'd3);

      // Randomized traffic checked by the per-cycle compare process
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         start_i   = ($urandom_range(0, 2) == 0);
         annul_i   = ($urandom_range(0, 40) == 0);
         op_i      = 3'($urandom_range(0, 7));
         opdata1_i = pick();
         opdata2_i = pick();
         hi_i      = W'($urandom);
         lo_i      = W'($urandom);
      end
      @(negedge clk);
      start_i = 1'b0;
      annul_i = 1'b0;
      repeat (W + 6) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
